// File: rtl/retire_trace_port_if.sv
// Trace stream from retire_trace_port to a downstream consumer.
// TRACE_CYCLE_STAMP_EN adds the per-record cycle stamp field.
interface retire_trace_port_if;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] stamp;

    modport master (
        output valid, pc, insn, rd_we, rd, rd_data,
        output rs1, rs2, rs1_data, rs2_data, stamp,
        input  ready
    );
    modport slave (
        input  valid, pc, insn, rd_we, rd, rd_data,
        input  rs1, rs2, rs1_data, rs2_data, stamp,
        output ready
    );
`else
    modport master (
        output valid, pc, insn, rd_we, rd, rd_data,
        output rs1, rs2, rs1_data, rs2_data,
        input  ready
    );
    modport slave (
        input  valid, pc, insn, rd_we, rd, rd_data,
        input  rs1, rs2, rs1_data, rs2_data,
        output ready
    );
`endif
endinterface

// File: rtl/retire_trace_port.sv
// Writeback retire trace capture: FIFO of retire records onto a trace stream.
// Optional TRACE_CYCLE_STAMP_EN stamps each record with a free-running cycle count.
module retire_trace_port #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 retire_valid,
    input  logic [31:0]          retire_pc,
    input  logic [31:0]          retire_insn,
    input  logic                 retire_rd_we,
    input  logic [4:0]           retire_rd,
    input  logic [31:0]          retire_rd_data,
    input  logic [4:0]           retire_rs1,
    input  logic [4:0]           retire_rs2,
    input  logic [31:0]          retire_rs1_data,
    input  logic [31:0]          retire_rs2_data,
    output logic                 stall_req,
    retire_trace_port_if.master  trace,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0] stamp;
`endif
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          rec_in;
    rec_t          head;
    logic          head_valid;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]   cycle;
`endif

    always_comb begin
        rec_in          = '0;
        rec_in.pc       = retire_pc;
        rec_in.insn     = retire_insn;
        rec_in.rd_we    = retire_rd_we;
        rec_in.rd       = retire_rd;
        rec_in.rd_data  = retire_rd_data;
        rec_in.rs1      = retire_rs1;
        rec_in.rs2      = retire_rs2;
        rec_in.rs1_data = retire_rs1_data;
        rec_in.rs2_data = retire_rs2_data;
`ifdef TRACE_CYCLE_STAMP_EN
        rec_in.stamp    = cycle;
`endif
    end

    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = head_valid & trace.ready;
    assign push    = retire_valid & (~full | pop);
    assign drop    = retire_valid & full & ~pop;
    assign rd_next = rd_ptr + AW'(pop);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= rec_in;
    end

    // Head register preloads the next head; an empty FIFO takes the incoming record.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
            stall_req  <= 1'b0;
            retire_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            count      <= count_next;
            rd_ptr     <= rd_next;
            head_valid <= (count_next != '0);
            stall_req  <= (count_next >= (AW+1)'(DEPTH-1));
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                retire_cnt <= retire_cnt + 1'b1;
            end
            if (count_next != '0) begin
                if (push && (wr_ptr == rd_next))
                    head <= rec_in;
                else
                    head <= mem[rd_next];
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

`ifdef TRACE_CYCLE_STAMP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cycle <= '0;
        else
            cycle <= cycle + 1'b1;
    end

    assign trace.stamp    = head.stamp;
`endif

    assign trace.valid    = head_valid;
    assign trace.pc       = head.pc;
    assign trace.insn     = head.insn;
    assign trace.rd_we    = head.rd_we;
    assign trace.rd       = head.rd;
    assign trace.rd_data  = head.rd_data;
    assign trace.rs1      = head.rs1;
    assign trace.rs2      = head.rs2;
    assign trace.rs1_data = head.rs1_data;
    assign trace.rs2_data = head.rs2_data;
endmodule

// File: tb/tb_retire_trace_port.sv
// Directed bench for retire_trace_port (DEPTH=4, CNT_W=32).
// Stamp scenario compiled only with TRACE_CYCLE_STAMP_EN.
module tb_retire_trace_port;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = '0;
    logic [31:0] retire_insn = '0;
    logic        retire_rd_we = 1'b0;
    logic [4:0]  retire_rd = '0;
    logic [31:0] retire_rd_data = '0;
    logic [4:0]  retire_rs1 = '0;
    logic [4:0]  retire_rs2 = '0;
    logic [31:0] retire_rs1_data = '0;
    logic [31:0] retire_rs2_data = '0;
    logic        stall_req;
    logic [31:0] retire_cnt;
    logic [31:0] drop_cnt;
    logic        overflow;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [31:0] BASE = 32'h0100_0000;

    retire_trace_port_if tr ();

    retire_trace_port #(.DEPTH(4), .CNT_W(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .retire_valid    (retire_valid),
        .retire_pc       (retire_pc),
        .retire_insn     (retire_insn),
        .retire_rd_we    (retire_rd_we),
        .retire_rd       (retire_rd),
        .retire_rd_data  (retire_rd_data),
        .retire_rs1      (retire_rs1),
        .retire_rs2      (retire_rs2),
        .retire_rs1_data (retire_rs1_data),
        .retire_rs2_data (retire_rs2_data),
        .stall_req       (stall_req),
        .trace           (tr),
        .retire_cnt      (retire_cnt),
        .drop_cnt        (drop_cnt),
        .overflow        (overflow)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        retire_valid = 1'b0;
        tr.ready     = 1'b0;
        reset        = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic set_rec(input logic [31:0] pc);
        retire_pc       = pc;
        retire_insn     = pc ^ 32'h0000_0013;
        retire_rd_we    = 1'b1;
        retire_rd       = pc[6:2];
        retire_rd_data  = ~pc;
        retire_rs1      = pc[7:3];
        retire_rs2      = 5'd0;
        retire_rs1_data = pc + 32'd1;
        retire_rs2_data = 32'hA5A5_0000;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (tr.valid !== 1'b0 || stall_req !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b stall=%b ovf=%b, need 0 0 0",
                     tr.valid, stall_req, overflow);
        end
        n_chk++;
        if (retire_cnt !== 32'd0 || drop_cnt !== 32'd0 || tr.pc !== 32'd0 || tr.rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: rc=%0d dc=%0d pc=%h rdd=%h, need zeros",
                     retire_cnt, drop_cnt, tr.pc, tr.rd_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        retire_pc       = BASE;
        retire_insn     = 32'h0050_0093;
        retire_rd_we    = 1'b1;
        retire_rd       = 5'd1;
        retire_rd_data  = 32'd5;
        retire_rs1      = 5'd0;
        retire_rs2      = 5'd0;
        retire_rs1_data = 32'd0;
        retire_rs2_data = 32'd0;
        retire_valid    = 1'b1;
        tr.ready        = 1'b1;
        step();
        retire_valid = 1'b0;
        n_chk++;
        if (tr.valid !== 1'b1 || tr.pc !== BASE || tr.insn !== 32'h0050_0093 ||
            tr.rd_we !== 1'b1 || tr.rd !== 5'd1 || tr.rd_data !== 32'd5 ||
            tr.rs1 !== 5'd0 || tr.rs2 !== 5'd0) begin
            n_fail++;
            $display("FAIL single_fields: v=%b pc=%h insn=%h we=%b rd=%0d d=%0d, need 1 %h 00500093 1 1 5",
                     tr.valid, tr.pc, tr.insn, tr.rd_we, tr.rd, tr.rd_data, BASE);
        end
        step();
        n_chk++;
        if (tr.valid !== 1'b0 || retire_cnt !== 32'd1 || tr.pc !== BASE) begin
            n_fail++;
            $display("FAIL single_after: v=%b rc=%0d pc=%h, need 0 1 %h (held)",
                     tr.valid, retire_cnt, tr.pc, BASE);
        end
    endtask

    task automatic fill4();
        tr.ready     = 1'b0;
        retire_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_rec(BASE + 32'(i * 4));
            step();
            n_chk++;
            if (stall_req !== (i >= 2) || tr.valid !== 1'b1 || tr.pc !== BASE) begin
                n_fail++;
                $display("FAIL fill_%0d: stall=%b v=%b pc=%h, need %b 1 %h",
                         i, stall_req, tr.valid, tr.pc, (i >= 2), BASE);
            end
        end
    endtask

    task automatic drain(input logic [31:0] exp [4]);
        retire_valid = 1'b0;
        tr.ready     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (tr.valid !== 1'b1 || tr.pc !== exp[i] || tr.rd_data !== ~exp[i] ||
                tr.rs1_data !== exp[i] + 32'd1) begin
                n_fail++;
                $display("FAIL drain_%0d: v=%b pc=%h rdd=%h, need 1 %h %h",
                         i, tr.valid, tr.pc, tr.rd_data, exp[i], ~exp[i]);
            end
            step();
        end
        n_chk++;
        if (tr.valid !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_end: v=%b stall=%b, need 0 0", tr.valid, stall_req);
        end
        tr.ready = 1'b0;
    endtask

    task automatic test_fill_drop();
        logic [31:0] exp [4];
        do_reset();
        fill4();
        set_rec(32'hDEAD_0000);
        step();
        retire_valid = 1'b0;
        n_chk++;
        if (drop_cnt !== 32'd1 || overflow !== 1'b1 || retire_cnt !== 32'd4 || stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL drop: dc=%0d ovf=%b rc=%0d stall=%b, need 1 1 4 1",
                     drop_cnt, overflow, retire_cnt, stall_req);
        end
        for (int i = 0; i < 4; i++) exp[i] = BASE + 32'(i * 4);
        drain(exp);
        n_chk++;
        if (overflow !== 1'b1 || drop_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL drop_sticky: ovf=%b dc=%0d, need 1 1", overflow, drop_cnt);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp [4];
        do_reset();
        fill4();
        set_rec(32'h0200_0000);
        tr.ready = 1'b1;
        step();
        retire_valid = 1'b0;
        tr.ready     = 1'b0;
        n_chk++;
        if (drop_cnt !== 32'd0 || retire_cnt !== 32'd5 || stall_req !== 1'b1 ||
            tr.pc !== BASE + 32'd4) begin
            n_fail++;
            $display("FAIL full_pp: dc=%0d rc=%0d stall=%b pc=%h, need 0 5 1 %h",
                     drop_cnt, retire_cnt, stall_req, tr.pc, BASE + 32'd4);
        end
        exp[0] = BASE + 32'd4;
        exp[1] = BASE + 32'd8;
        exp[2] = BASE + 32'd12;
        exp[3] = 32'h0200_0000;
        drain(exp);
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        do_reset();
        tr.ready     = 1'b1;
        retire_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_rec(BASE + 32'(i * 4));
            step();
            n_chk++;
            if (tr.valid !== 1'b1 || tr.pc !== BASE + 32'(i * 4) || stall_req !== 1'b0) begin
                n_fail++;
                bad++;
                if (bad < 4)
                    $display("FAIL stream_%0d: v=%b pc=%h stall=%b, need 1 %h 0",
                             i, tr.valid, tr.pc, stall_req, BASE + 32'(i * 4));
            end
        end
        retire_valid = 1'b0;
        step();
        n_chk++;
        if (drop_cnt !== 32'd0 || retire_cnt !== 32'd20 || tr.valid !== 1'b0 ||
            tr.pc !== BASE + 32'h4C) begin
            n_fail++;
            $display("FAIL stream_end: dc=%0d rc=%0d v=%b pc=%h, need 0 20 0 %h",
                     drop_cnt, retire_cnt, tr.valid, tr.pc, BASE + 32'h4C);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tr.ready     = 1'b0;
        retire_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rec(BASE + 32'(i * 4));
            step();
        end
        retire_valid = 1'b0;
        n_chk++;
        if (stall_req !== 1'b1 || tr.valid !== 1'b1 || retire_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL pre_areset: stall=%b v=%b rc=%0d, need 1 1 3",
                     stall_req, tr.valid, retire_cnt);
        end
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if (tr.valid !== 1'b0 || retire_cnt !== 32'd0 || stall_req !== 1'b0 || tr.pc !== 32'd0) begin
            n_fail++;
            $display("FAIL areset: v=%b rc=%0d stall=%b pc=%h, need 0 0 0 0",
                     tr.valid, retire_cnt, stall_req, tr.pc);
        end
        step();
        reset    = 1'b1;
        tr.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (tr.valid !== 1'b0 || retire_cnt !== 32'd0) begin
                n_fail++;
                $display("FAIL stale_%0d: v=%b rc=%0d, need 0 0", i, tr.valid, retire_cnt);
            end
        end
        tr.ready = 1'b0;
    endtask

`ifdef TRACE_CYCLE_STAMP_EN
    task automatic test_stamp();
        do_reset();
        tr.ready     = 1'b0;
        retire_valid = 1'b0;
        step();
        step();
        set_rec(BASE);
        retire_valid = 1'b1;
        step();
        retire_valid = 1'b0;
        repeat (4) step();
        set_rec(BASE + 32'd4);
        retire_valid = 1'b1;
        step();
        retire_valid = 1'b0;
        n_chk++;
        if (tr.valid !== 1'b1 || tr.stamp !== 32'd2) begin
            n_fail++;
            $display("FAIL stamp_0: v=%b stamp=%0d, need 1 2", tr.valid, tr.stamp);
        end
        tr.ready = 1'b1;
        step();
        tr.ready = 1'b0;
        n_chk++;
        if (tr.valid !== 1'b1 || tr.stamp !== 32'd7) begin
            n_fail++;
            $display("FAIL stamp_1: v=%b stamp=%0d, need 1 7", tr.valid, tr.stamp);
        end
    endtask
`endif

    initial begin
        tr.ready = 1'b0;
        test_reset();
        test_single();
        test_fill_drop();
        test_full_push_pop();
        test_back_to_back();
        test_async_reset();
`ifdef TRACE_CYCLE_STAMP_EN
        test_stamp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
